// File: rtl/legup_skid_pkg.sv
// Shared types and constants for the legup_skid_register pipeline stage.
package legup_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned STALL_CNT_W = 16;

endpackage : legup_skid_pkg

// File: rtl/legup_skid_stall_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module legup_skid_stall_counter
  import legup_skid_pkg::*;
#(
  parameter int unsigned width = STALL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [width-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule : legup_skid_stall_counter

// File: rtl/legup_skid_register.sv
// Valid/ready pipeline stage with a two-entry skid buffer; handshake outputs decode from state only.
// Optional stall counter port enabled by defining LEGUP_SKID_STALL_CNT_EN.
module legup_skid_register
  import legup_skid_pkg::*;
#(
  parameter int unsigned     width      = 32,
  parameter logic [width-1:0] init_value = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data
`ifdef LEGUP_SKID_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_count
`endif
);

  skid_state_t      state, state_n;
  logic [width-1:0] main_q, skid_q;
  logic             in_acc, out_acc;
  logic             load_main, load_skid, main_from_skid;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (in_acc) begin
          state_n   = BUSY;
          load_main = 1'b1;
        end
      end
      BUSY: begin
        if (in_acc && out_acc) begin
          load_main = 1'b1;
        end else if (in_acc) begin
          state_n   = FULL;
          load_skid = 1'b1;
        end else if (out_acc) begin
          state_n = EMPTY;
        end
      end
      FULL: begin
        if (out_acc) begin
          state_n        = BUSY;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= init_value;
      skid_q <= init_value;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

`ifdef LEGUP_SKID_STALL_CNT_EN
  legup_skid_stall_counter #(
    .width(STALL_CNT_W)
  ) u_stall_counter (
    .clk  (clk),
    .reset(reset),
    .inc  (out_valid && !out_ready),
    .count(stall_count)
  );
`endif

endmodule : legup_skid_register

// File: tb/tb_legup_skid_register.sv
// Self-checking bench for legup_skid_register: vector table, FIFO scoreboard, reset and stall corners.
module tb_legup_skid_register;

  localparam logic [31:0] INIT = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef LEGUP_SKID_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  legup_skid_register #(
    .width     (32),
    .init_value(INIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef LEGUP_SKID_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_data;
  } vec_t;

  vec_t vec[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model, step the model.
  task automatic cycle(input logic iv, input logic [31:0] d, input logic ordy);
    logic ia, oa;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("sb_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("sb_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) chk("sb_out_data", out_data, q[0]);
    ia = iv && (q.size() < 2);
    oa = ordy && (q.size() > 0);
    if (oa) void'(q.pop_front());
    if (ia) q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic iv, input logic [31:0] d);
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = iv;
    in_data   = d;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, INIT);
`ifdef LEGUP_SKID_STALL_CNT_EN
    chk("rst_stall_count", {16'd0, stall_count}, 32'd0);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // iv, d, ordy -> expected out_valid, in_ready, out_data after the edge
    vec[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b1, 32'h11};
    vec[1] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h11};
    vec[2] = '{1'b1, 32'h0A, 1'b0, 1'b1, 1'b1, 32'h0A};
    vec[3] = '{1'b1, 32'h0B, 1'b0, 1'b1, 1'b0, 32'h0A};
    vec[4] = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0A};
    vec[5] = '{1'b1, 32'h0C, 1'b1, 1'b1, 1'b1, 32'h0B};
    vec[6] = '{1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 32'h0B};
    vec[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h0C};
    vec[8] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b1, 32'h0C};
    vec[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h0C};

    repeat (2) @(posedge clk);
    do_reset(1'b0, '0);

    for (int i = 0; i < 10; i++) begin
      cycle(vec[i].iv, vec[i].d, vec[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].e_valid});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vec[i].e_ready});
      chk($sformatf("vec%0d_out_data", i), out_data, vec[i].e_data);
    end

    // Back-to-back stream: after the first word, a new word appears every cycle.
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, i, 1'b1);
      chk($sformatf("stream%0d_data", i), out_data, i);
    end
    cycle(1'b0, '0, 1'b1);
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Randomised traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) != 0);
    end

    // Reset while FULL with a coincident input: everything discarded.
    do_reset(1'b0, '0);
    cycle(1'b1, 32'h21, 1'b0);
    cycle(1'b1, 32'h22, 1'b0);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    do_reset(1'b1, 32'h99);
    cycle(1'b0, '0, 1'b1);
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);
    chk("post_rst_data", out_data, INIT);

`ifdef LEGUP_SKID_STALL_CNT_EN
    do_reset(1'b0, '0);
    cycle(1'b1, 32'h55, 1'b0);
    repeat (5) cycle(1'b0, '0, 1'b0);
    chk("stall_count_5", {16'd0, stall_count}, 32'd5);
    repeat (70000) cycle(1'b0, '0, 1'b0);
    chk("stall_count_sat", {16'd0, stall_count}, 32'h0000_FFFF);
    do_reset(1'b0, '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_legup_skid_register
